icap_select_ctrl: RTL and testbench

Parametrised Tube-side design-select and reconfiguration controller for the multiboot FPGA flow. It runs entirely in the `fastclk` domain. Tube host writes are captured through a synchroniser rather than clocked on `h_phi2`. The block debounces the DIP switches, arbitrates between software and hardware design requests, and drives the ICAP core through a req/ack handshake, gated on parasite or host reset.

---
 rtl/icap_select_ctrl.sv | 140 ++++++++++++++
 tb/tb_icap_select_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_select_ctrl.sv
// Tube-side design-select register, DIP-switch debounce and ICAP reconfiguration
// request sequencer; all host signals are sampled into the fastclk domain.
module icap_select_ctrl #(
  parameter int                     DESIGN_BITS = 5,
  parameter int                     NUM_SW      = 4,
  parameter logic [2:0]             SEL_ADDR    = 3'b110,
  parameter logic [DESIGN_BITS-1:0] HW_DESIGN   = 5'b10000,
  parameter int                     DEBOUNCE    = 1024
) (
  input  logic                   fastclk,
  input  logic                   rst,
  input  logic [2:0]             h_addr,
  input  logic                   h_cs_b,
  input  logic [7:0]             h_data,
  input  logic                   h_phi2,
  input  logic                   h_rdnw,
  input  logic                   h_rst_b,
  input  logic [NUM_SW-1:0]      sw_in,
  input  logic [NUM_SW-1:0]      pwr_sw,
  input  logic                   initialized,
  input  logic                   reconfig_ack,
  output logic [DESIGN_BITS-1:0] design_num,
  output logic                   reconfig_req,
  output logic                   p_rst_b,
  output logic [7:0]             status
);

  localparam int                CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ISSUE = 2'd2, DONE = 2'd3} state_t;

  state_t state_reg, state_next;

  logic phi2_s1, phi2_s2, phi2_prev;
  logic cs_s1, cs_s2, rdnw_s1, rdnw_s2, rst_b_s1, rst_b_s2;
  logic [2:0] addr_reg, hold_addr;
  logic [7:0] data_reg, hold_data;
  logic hold_cs, hold_rdnw;
  logic wr_stb, host_wr;

  logic [DESIGN_BITS-1:0] sel_num, effective;
  logic sw_pending, hw_pending;
  logic [NUM_SW-1:0] sw_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge fastclk) begin
    if (rst) begin
      phi2_s1   <= 1'b0; phi2_s2 <= 1'b0; phi2_prev <= 1'b0;
      cs_s1     <= 1'b1; cs_s2   <= 1'b1;
      rdnw_s1   <= 1'b1; rdnw_s2 <= 1'b1;
      rst_b_s1  <= 1'b1; rst_b_s2 <= 1'b1;
      addr_reg  <= '0;   data_reg <= '0;
      hold_addr <= '0;   hold_data <= '0;
      hold_cs   <= 1'b1; hold_rdnw <= 1'b1;
    end else begin
      phi2_s1   <= h_phi2;  phi2_s2  <= phi2_s1; phi2_prev <= phi2_s2;
      cs_s1     <= h_cs_b;  cs_s2    <= cs_s1;
      rdnw_s1   <= h_rdnw;  rdnw_s2  <= rdnw_s1;
      rst_b_s1  <= h_rst_b; rst_b_s2 <= rst_b_s1;
      addr_reg  <= h_addr;  data_reg <= h_data;
      // The bus is stable throughout phi2 high; the last copy is what gets decoded.
      if (phi2_s2) begin
        hold_addr <= addr_reg;
        hold_data <= data_reg;
        hold_cs   <= cs_s2;
        hold_rdnw <= rdnw_s2;
      end
    end
  end

  assign wr_stb  = phi2_prev & ~phi2_s2;
  assign host_wr = wr_stb & ~hold_cs & ~hold_rdnw & (state_reg != DONE);

  always_ff @(posedge fastclk) begin
    if (rst) begin
      p_rst_b    <= 1'b1;
      sel_num    <= '0;
      sw_pending <= 1'b0;
    end else if (host_wr) begin
      if (hold_addr == 3'd0) begin
        if (hold_data[7] && hold_data[6]) p_rst_b <= 1'b1;
        else if (hold_data[5])            p_rst_b <= ~hold_data[7];
      end
      if (hold_addr == SEL_ADDR) begin
        sel_num    <= hold_data[DESIGN_BITS-1:0];
        sw_pending <= 1'b1;
      end
    end
  end

  // Switch debounce: count only while the switches are steady and away from power-up value.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      sw_prev    <= '0;
      cnt        <= '0;
      hw_pending <= 1'b0;
    end else begin
      sw_prev <= sw_in;
      if (state_reg != DONE) begin
        if (!initialized || sw_in != sw_prev || sw_in == pwr_sw) cnt <= '0;
        else if (cnt != DEB_MAX)                                 cnt <= cnt + CNT_W'(1);
        if (initialized && sw_in == pwr_sw && (state_reg == IDLE || state_reg == ARMED))
          hw_pending <= 1'b0;
        else if (initialized && cnt == DEB_MAX)
          hw_pending <= 1'b1;
      end
    end
  end

  assign effective = hw_pending ? HW_DESIGN : sel_num;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hw_pending || sw_pending) state_next = ARMED;
      ARMED: begin
        if (!(hw_pending || sw_pending))   state_next = IDLE;
        else if (!p_rst_b || !rst_b_s2)    state_next = ISSUE;
      end
      ISSUE:   if (reconfig_ack) state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (rst) begin
      state_reg    <= IDLE;
      reconfig_req <= 1'b0;
      design_num   <= '0;
    end else begin
      state_reg    <= state_next;
      reconfig_req <= (state_next == ISSUE);
      if (state_reg == ARMED && state_next == ISSUE) design_num <= effective;
    end
  end

  assign status = {state_reg, hw_pending, sw_pending, design_num[3:0]};

endmodule

// File: tb/tb_icap_select_ctrl.sv
// Scenario bench for icap_select_ctrl: expected design numbers are queued when
// stimulus is driven and popped when the request appears.
module tb_icap_select_ctrl;

  localparam int DEB = 1024;
  localparam logic [2:0] SEL = 3'b110;

  logic       fastclk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] h_addr = '0;
  logic       h_cs_b = 1'b1;
  logic [7:0] h_data = '0;
  logic       h_phi2 = 1'b0;
  logic       h_rdnw = 1'b1;
  logic       h_rst_b = 1'b1;
  logic [3:0] sw_in = '0;
  logic [3:0] pwr_sw = '0;
  logic       initialized = 1'b0;
  logic       reconfig_ack = 1'b0;
  logic [4:0] design_num;
  logic       reconfig_req;
  logic       p_rst_b;
  logic [7:0] status;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  logic [4:0] exp_q[$];

  icap_select_ctrl #(.DEBOUNCE(DEB)) dut (
    .fastclk(fastclk), .rst(rst), .h_addr(h_addr), .h_cs_b(h_cs_b), .h_data(h_data),
    .h_phi2(h_phi2), .h_rdnw(h_rdnw), .h_rst_b(h_rst_b), .sw_in(sw_in), .pwr_sw(pwr_sw),
    .initialized(initialized), .reconfig_ack(reconfig_ack), .design_num(design_num),
    .reconfig_req(reconfig_req), .p_rst_b(p_rst_b), .status(status)
  );

  always #5 fastclk = ~fastclk;

  always @(negedge fastclk) if (reconfig_req) req_cycles++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fastclk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; h_phi2 = 1'b0; h_cs_b = 1'b1; h_rdnw = 1'b1; h_addr = '0; h_data = '0;
    h_rst_b = 1'b1; sw_in = '0; pwr_sw = '0; initialized = 1'b0; reconfig_ack = 1'b0;
    exp_q.delete();
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    h_addr = a; h_data = d; h_cs_b = 1'b0; h_rdnw = 1'b0; h_phi2 = 1'b1;
    tick(4);
    h_phi2 = 1'b0;
    tick(1);
    h_cs_b = 1'b1; h_rdnw = 1'b1;
    tick(6);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (p_rst_b !== 1'b1) begin errors++; $display("FAIL reset_p_rst_b: got %b expected 1", p_rst_b); end
    checks++; if (reconfig_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", reconfig_req); end
    checks++; if (design_num !== 5'd0) begin errors++; $display("FAIL reset_design_num: got %h expected 00", design_num); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status); end
    $display("reset: p_rst_b=%b req=%b status=%h", p_rst_b, reconfig_req, status);
  endtask

  task automatic test_sw_select;
    logic [4:0] exp;
    do_reset();
    host_write(SEL, 8'h05);
    $display("write sel 05: status=%h req=%b", status, reconfig_req);
    checks++; if (status[7:6] !== 2'd1) begin errors++; $display("FAIL sw_armed: state %0d expected 1", status[7:6]); end
    checks++; if (reconfig_req !== 1'b0) begin errors++; $display("FAIL sw_no_req: got %b expected 0", reconfig_req); end
    exp_q.push_back(5'h05);
    host_write(3'd0, 8'hA0);
    $display("write addr0 A0: p_rst_b=%b req=%b design_num=%h", p_rst_b, reconfig_req, design_num);
    checks++; if (p_rst_b !== 1'b0) begin errors++; $display("FAIL sw_p_rst_b: got %b expected 0", p_rst_b); end
    checks++; if (reconfig_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b expected 1", reconfig_req); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL sw_design: scoreboard empty"); end
    else begin
      exp = exp_q.pop_front();
      if (design_num !== exp) begin errors++; $display("FAIL sw_design: got %h expected %h", design_num, exp); end
    end
    reconfig_ack = 1'b1;
    tick(2);
    reconfig_ack = 1'b0;
    $display("ack: status=%h req=%b", status, reconfig_req);
    checks++; if (status[7:6] !== 2'd3) begin errors++; $display("FAIL sw_done: state %0d expected 3", status[7:6]); end
    checks++; if (reconfig_req !== 1'b0) begin errors++; $display("FAIL sw_done_req: got %b expected 0", reconfig_req); end
    host_write(3'd0, 8'h20);
    $display("write addr0 20 in DONE: p_rst_b=%b", p_rst_b);
    checks++; if (p_rst_b !== 1'b0) begin errors++; $display("FAIL done_ignores_write: got %b expected 0", p_rst_b); end
  endtask

  task automatic test_p_rst;
    logic [7:0] wd [6];
    logic       we [6];
    wd = '{8'hA0, 8'h20, 8'hC0, 8'h80, 8'hA0, 8'h80};
    we = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      host_write(3'd0, wd[i]);
      $display("write addr0 %h: p_rst_b=%b", wd[i], p_rst_b);
      checks++;
      if (p_rst_b !== we[i]) begin errors++; $display("FAIL p_rst_seq%0d: got %b expected %b", i, p_rst_b, we[i]); end
    end
  endtask

  task automatic test_hw_debounce;
    logic [4:0] exp;
    do_reset();
    initialized = 1'b1; pwr_sw = 4'h3; sw_in = 4'h3;
    tick(4);
    sw_in = 4'h7;
    tick(DEB - 1);
    sw_in = 4'h3;
    tick(3);
    $display("short hold: status=%h", status);
    checks++; if (status[5] !== 1'b0) begin errors++; $display("FAIL hw_short: hw_pending %b expected 0", status[5]); end
    checks++; if (status[7:6] !== 2'd0) begin errors++; $display("FAIL hw_short_state: state %0d expected 0", status[7:6]); end
    sw_in = 4'h7;
    tick(DEB + 3);
    $display("long hold: status=%h", status);
    checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL hw_long: hw_pending %b expected 1", status[5]); end
    checks++; if (status[7:6] !== 2'd1) begin errors++; $display("FAIL hw_armed: state %0d expected 1", status[7:6]); end
    exp_q.push_back(5'h10);
    h_rst_b = 1'b0;
    tick(6);
    $display("host reset low: req=%b design_num=%h", reconfig_req, design_num);
    checks++; if (reconfig_req !== 1'b1) begin errors++; $display("FAIL hw_req: got %b expected 1", reconfig_req); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL hw_design: scoreboard empty"); end
    else begin
      exp = exp_q.pop_front();
      if (design_num !== exp) begin errors++; $display("FAIL hw_design: got %h expected %h", design_num, exp); end
    end
    h_rst_b = 1'b1;
  endtask

  task automatic test_glitch;
    do_reset();
    initialized = 1'b1; pwr_sw = 4'h3; sw_in = 4'h3;
    tick(4);
    for (int i = 0; i < 500; i++) begin
      sw_in = (i % 2 == 1) ? 4'h7 : 4'hB;
      tick(10);
      if (i % 100 == 99) begin
        $display("glitch step %0d: status=%h", i, status);
        checks++;
        if (status[7:4] !== 4'h0) begin errors++; $display("FAIL glitch_%0d: status[7:4] %h expected 0", i, status[7:4]); end
      end
    end
    sw_in = 4'hB;
    tick(DEB + 3);
    $display("steady after glitch: status=%h", status);
    checks++; if (status[7:5] !== 3'b011) begin errors++; $display("FAIL glitch_steady: status[7:5] %b expected 011", status[7:5]); end
    sw_in = 4'h3;
    tick(3);
    $display("switch restored: status=%h", status);
    checks++; if (status[7:4] !== 4'h0) begin errors++; $display("FAIL hw_clear: status[7:4] %h expected 0", status[7:4]); end
  endtask

  task automatic test_arbitration;
    logic [4:0] exp;
    do_reset();
    initialized = 1'b1; pwr_sw = 4'h3; sw_in = 4'h3;
    tick(4);
    sw_in = 4'h7;
    tick(DEB + 3);
    host_write(SEL, 8'h03);
    $display("both pending: status=%h", status);
    checks++; if (status[7:4] !== 4'b0111) begin errors++; $display("FAIL arb_pending: status[7:4] %b expected 0111", status[7:4]); end
    exp_q.push_back(5'h10);
    h_rst_b = 1'b0;
    tick(6);
    $display("arb issue: req=%b design_num=%h", reconfig_req, design_num);
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL arb_design: scoreboard empty"); end
    else begin
      exp = exp_q.pop_front();
      if (design_num !== exp) begin errors++; $display("FAIL arb_design: got %h expected %h", design_num, exp); end
    end
    host_write(SEL, 8'h09);
    $display("write sel 09 in ISSUE: req=%b design_num=%h", reconfig_req, design_num);
    checks++; if (design_num !== 5'h10) begin errors++; $display("FAIL arb_frozen: got %h expected 10", design_num); end
    checks++; if (reconfig_req !== 1'b1) begin errors++; $display("FAIL arb_hold_req: got %b expected 1", reconfig_req); end
    rst = 1'b1;
    tick(1);
    $display("rst in ISSUE: req=%b status=%h", reconfig_req, status);
    checks++; if (reconfig_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", reconfig_req); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL rst_status: got %h expected 00", status); end
    rst = 1'b0;
    h_rst_b = 1'b1;
    tick(2);
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp;
    do_reset();
    reconfig_ack = 1'b1;
    h_rst_b = 1'b0;
    tick(3);
    req_cycles = 0;
    exp_q.push_back(5'h0A);
    host_write(SEL, 8'h0A);
    $display("early ack: req_cycles=%0d status=%h design_num=%h", req_cycles, status, design_num);
    checks++; if (req_cycles != 1) begin errors++; $display("FAIL early_ack_pulse: got %0d cycles expected 1", req_cycles); end
    checks++; if (status[7:6] !== 2'd3) begin errors++; $display("FAIL early_ack_done: state %0d expected 3", status[7:6]); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL early_ack_design: scoreboard empty"); end
    else begin
      exp = exp_q.pop_front();
      if (design_num !== exp) begin errors++; $display("FAIL early_ack_design: got %h expected %h", design_num, exp); end
    end
    reconfig_ack = 1'b0;
    h_rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sw_select();
    test_p_rst();
    test_hw_debounce();
    test_glitch();
    test_arbitration();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
